// File: rtl/alu_cmd_issuer.sv
// ----------------------------------------------------------------------------
// alu_cmd_issuer
//
// Issue stage in front of an 8-bit combinational ALU. Commands (A, B, op)
// arrive from a producer and are buffered in a small FIFO. Commands go onto the
// registered alu_a/alu_b/alu_op outputs one at a time. One clock after issue,
// the ALU result alu_r is captured. The captured result is then offered on a
// result port until the consumer takes it. Only one command is in flight at a
// time, so results leave in the same order the commands arrived.
//
// Handshakes (both ports): a transfer happens on a rising clock edge where
// valid and ready are both 1. A source holds valid and its payload stable
// until that edge. ready may depend only on registered state.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        synchronous active-low reset
//   cmd_valid  in   1        producer has a command
//   cmd_ready  out  1        FIFO has room (0 while rst_n is low)
//   cmd_a      in   WIDTH    operand A
//   cmd_b      in   WIDTH    operand B
//   cmd_op     in   OPW      ALU opcode
//   alu_a      out  WIDTH    registered operand A to the ALU
//   alu_b      out  WIDTH    registered operand B to the ALU
//   alu_op     out  OPW      registered opcode to the ALU
//   alu_r      in   WIDTH    ALU result
//   res_valid  out  1        res_data/res_op hold a captured result
//   res_ready  in   1        consumer accepts the result
//   res_data   out  WIDTH    captured alu_r
//   res_op     out  OPW      opcode that produced res_data
//   fifo_count out  CNT_W    commands currently buffered
//   dbg_state  out  2        FSM state (0 IDLE, 1 EXEC, 2 WAIT)
// ----------------------------------------------------------------------------
module alu_cmd_issuer #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [WIDTH-1:0]             cmd_a,
    input  logic [WIDTH-1:0]             cmd_b,
    input  logic [OPW-1:0]               cmd_op,
    output logic [WIDTH-1:0]             alu_a,
    output logic [WIDTH-1:0]             alu_b,
    output logic [OPW-1:0]               alu_op,
    input  logic [WIDTH-1:0]             alu_r,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [WIDTH-1:0]             res_data,
    output logic [OPW-1:0]               res_op,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic [1:0]                   dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_mem_a  [DEPTH];
    logic [WIDTH-1:0]   r_mem_b  [DEPTH];
    logic [OPW-1:0]     r_mem_op [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [OPW-1:0]     r_alu_op;
    logic               r_res_valid;
    logic [WIDTH-1:0]   r_res_data;
    logic [OPW-1:0]     r_res_op;

    logic               w_push;
    logic               w_not_empty;
    logic               w_issue;      // load FIFO head onto alu_* and pop
    logic               w_capture;    // sample alu_r into the result register
    logic               w_res_clear;  // result handed to the consumer

    // Room is judged from the registered count only. A pop in the same cycle
    // therefore never opens a slot for a push while the FIFO is full.
    assign cmd_ready   = rst_n && (r_count < CNT_W'(DEPTH));
    assign w_push      = cmd_valid && cmd_ready;
    assign w_not_empty = (r_count != '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        w_res_clear = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_not_empty) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                // alu_* were loaded on the previous edge. alu_r is valid now.
                w_capture   = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_res_valid && res_ready) begin
                    w_res_clear = 1'b1;
                    // Chain straight into the next command to keep the
                    // result rate at one result every two cycles.
                    if (w_not_empty) begin
                        w_issue     = 1'b1;
                        w_state_nxt = S_EXEC;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command FIFO storage (contents need no reset; pointers gate them)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]  <= cmd_a;
            r_mem_b[r_wr_ptr]  <= cmd_b;
            r_mem_op[r_wr_ptr] <= cmd_op;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // ALU drive and result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_op    <= '0;
        end else begin
            if (w_issue) begin
                r_alu_a  <= r_mem_a[r_rd_ptr];
                r_alu_b  <= r_mem_b[r_rd_ptr];
                r_alu_op <= r_mem_op[r_rd_ptr];
            end
            if (w_capture) begin
                r_res_data  <= alu_r;
                r_res_op    <= r_alu_op;
                r_res_valid <= 1'b1;
            end else if (w_res_clear) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_op     = r_res_op;
    assign fifo_count = r_count;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;

  localparam int WIDTH = 8;
  localparam int OPW   = 3;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  localparam logic [31:0] ST_IDLE = 32'd0;
  localparam logic [31:0] ST_EXEC = 32'd1;
  localparam logic [31:0] ST_WAIT = 32'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [OPW-1:0]   cmd_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_r;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [OPW-1:0]   res_op;
  logic [CNT_W-1:0] fifo_count;
  logic [1:0]       dbg_state;

  alu_cmd_issuer #(.WIDTH(WIDTH), .OPW(OPW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_r      (alu_r),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_op     (res_op),
    .fifo_count (fifo_count),
    .dbg_state  (dbg_state)
  );

  // Combinational ALU stand-in
  always_comb begin
    alu_r = '0;
    case (alu_op)
      3'd0: alu_r = alu_a + alu_b;
      3'd1: alu_r = ~alu_a;
      3'd2: alu_r = alu_a - alu_b;
      3'd3: alu_r = alu_a | alu_b;
      3'd4: alu_r = alu_a ^ alu_b;
      3'd5: alu_r = alu_a & alu_b;
      3'd6: alu_r = alu_a << 1;
      default: alu_r = alu_b;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [OPW+WIDTH-1:0] exp_q[$];
  logic [OPW+WIDTH-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every result handshake pops one expected entry
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL res_unexpected: got data 0x%0h op %0d expected no result", res_data, res_op);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_data", 32'(res_data), 32'(mon_e[WIDTH-1:0]));
        check("res_op", 32'(res_op), 32'(mon_e[OPW+WIDTH-1:WIDTH]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [7:0] exp_r);
    int waited = 0;
    bit done = 1'b0;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_valid = 1'b1;
    while (!done && waited < 200) begin
      @(negedge clk);
      if (cmd_ready) begin
        exp_q.push_back({op, exp_r});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    cmd_valid = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL send_timeout: cmd_ready stayed 0 for %0d cycles, expected 1", waited);
    end
  endtask

  task automatic drain();
    int n = 0;
    res_ready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d results outstanding expected 0", exp_q.size());
    end
    idle(2);
  endtask

  // One edge with a command offered and res_ready=1; no waiting.
  task automatic push_with_pop(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                               input logic [7:0] exp_r, input logic exp_ready, input string name);
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_valid = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    check(name, 32'(cmd_ready), 32'(exp_ready));
    if (cmd_ready) exp_q.push_back({op, exp_r});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
  endtask

  // T4 vectors: A + 0x80 with 8-bit wrap
  logic [7:0] t4_a [10] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
  logic [7:0] t4_r [10] = '{8'h80, 8'h91, 8'hA2, 8'hB3, 8'hC4, 8'hD5, 8'hE6, 8'hF7, 8'h08, 8'h19};

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    cmd_valid = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_op = '0;
    res_ready = 1'b0;
    rst_n = 1'b0;
    idle(2);

    // Reset state
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_state", 32'(dbg_state), ST_IDLE);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    rst_n = 1'b1;
    idle(1);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // T1: latency of a single add
    send(8'hAA, 8'h55, 3'd0, 8'hFF);
    check("t1_e0_count", 32'(fifo_count), 32'd1);
    check("t1_e0_res_valid", 32'(res_valid), 32'd0);
    idle(1);
    check("t1_e1_res_valid", 32'(res_valid), 32'd0);
    check("t1_e1_alu_a", 32'(alu_a), 32'hAA);
    check("t1_e1_alu_b", 32'(alu_b), 32'h55);
    check("t1_e1_alu_op", 32'(alu_op), 32'd0);
    check("t1_e1_count", 32'(fifo_count), 32'd0);
    check("t1_e1_state", 32'(dbg_state), ST_EXEC);
    idle(1);
    check("t1_e2_res_valid", 32'(res_valid), 32'd1);
    check("t1_e2_res_data", 32'(res_data), 32'hFF);
    check("t1_e2_state", 32'(dbg_state), ST_WAIT);
    drain();

    // T2: other opcodes and wrap
    send(8'hAA, 8'h00, 3'd1, 8'h55);
    send(8'hAA, 8'h55, 3'd5, 8'h00);
    send(8'hFF, 8'h01, 3'd0, 8'h00);
    send(8'h3C, 8'h0F, 3'd4, 8'h33);
    drain();

    // T3: back-pressure fills the FIFO
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'(8'h10 + i), 8'h01, 3'd0, 8'(8'h11 + i));
    check("t3_count_full", 32'(fifo_count), 32'd4);
    check("t3_cmd_ready_full", 32'(cmd_ready), 32'd0);
    check("t3_state", 32'(dbg_state), ST_WAIT);
    check("t3_res_valid", 32'(res_valid), 32'd1);
    check("t3_res_data", 32'(res_data), 32'h11);
    cmd_a = 8'h77;
    cmd_b = 8'h77;
    cmd_op = 3'd0;
    cmd_valid = 1'b1;
    idle(3);
    cmd_valid = 1'b0;
    check("t3_held_count", 32'(fifo_count), 32'd4);
    check("t3_held_ready", 32'(cmd_ready), 32'd0);
    check("t3_stable_data", 32'(res_data), 32'h11);
    check("t3_stable_op", 32'(res_op), 32'd0);
    check("t3_stable_valid", 32'(res_valid), 32'd1);
    drain();

    // T4: stream of 10 with the consumer always ready
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(t4_a[i], 8'h80, 3'd0, t4_r[i]);
    drain();
    check("t4_empty_count", 32'(fifo_count), 32'd0);
    check("t4_idle_state", 32'(dbg_state), ST_IDLE);

    // T5: simultaneous push/pop at count 2, then rejected push at count 4
    res_ready = 1'b0;
    send(8'h01, 8'h01, 3'd0, 8'h02);
    send(8'h0F, 8'hF0, 3'd3, 8'hFF);
    send(8'h81, 8'h00, 3'd6, 8'h02);
    check("t5_count2", 32'(fifo_count), 32'd2);
    check("t5_state_wait", 32'(dbg_state), ST_WAIT);
    push_with_pop(8'h40, 8'h02, 3'd2, 8'h3E, 1'b1, "t5_ready_at2");
    check("t5_pushpop_count", 32'(fifo_count), 32'd2);
    check("t5_state_exec", 32'(dbg_state), ST_EXEC);
    send(8'h12, 8'h34, 3'd7, 8'h34);
    send(8'hF0, 8'h3C, 3'd5, 8'h30);
    check("t5_count4", 32'(fifo_count), 32'd4);
    push_with_pop(8'hEE, 8'hEE, 3'd0, 8'hDC, 1'b0, "t5_ready_at4");
    check("t5_full_pop_count", 32'(fifo_count), 32'd3);
    drain();
    check("t5_drained_count", 32'(fifo_count), 32'd0);
    check("t5_res_valid_low", 32'(res_valid), 32'd0);

    // T6: reset while EXEC with 3 queued
    res_ready = 1'b0;
    send(8'h01, 8'h02, 3'd0, 8'h03);
    send(8'h02, 8'h02, 3'd0, 8'h04);
    send(8'h03, 8'h02, 3'd0, 8'h05);
    send(8'h04, 8'h02, 3'd0, 8'h06);
    push_with_pop(8'h05, 8'h02, 3'd0, 8'h07, 1'b1, "t6_ready");
    check("t6_pre_state", 32'(dbg_state), ST_EXEC);
    check("t6_pre_count", 32'(fifo_count), 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_ready_in_reset", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    exp_q.delete();
    check("t6_state", 32'(dbg_state), ST_IDLE);
    check("t6_count", 32'(fifo_count), 32'd0);
    check("t6_res_valid", 32'(res_valid), 32'd0);
    check("t6_alu_a", 32'(alu_a), 32'd0);
    check("t6_alu_b", 32'(alu_b), 32'd0);
    check("t6_alu_op", 32'(alu_op), 32'd0);
    check("t6_res_data", 32'(res_data), 32'd0);
    check("t6_res_op", 32'(res_op), 32'd0);
    rst_n = 1'b1;
    idle(2);
    check("t6_after_state", 32'(dbg_state), ST_IDLE);
    check("t6_after_alu_a", 32'(alu_a), 32'd0);
    check("t6_after_ready", 32'(cmd_ready), 32'd1);
    send(8'h20, 8'h22, 3'd0, 8'h42);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
